hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 Parameter RW, $clog2(NREG), register-index width.
REQ-003 Parameter LW, 3, latency-field width; maximum write latency is 2**LW-1.
REQ-004 Parameter SCW, 16, stall-counter width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 change_flow  input  1  jump or branch mispredict resolved this cycle.
REQ-008 id_rs, id_rt  input  RW each  source registers of the instruction in ID.
REQ-009 rs_read, rt_read  input  1 each  source is actually read.
REQ-010 issue_valid  input  1  ID holds a valid instruction.
REQ-011 issue_wen  input  1  that instruction writes a register.
REQ-012 issue_dst  input  RW  destination register.
REQ-013 issue_lat  input  LW  cycles until the result is readable in ID; 0 = readable next cycle.
REQ-014 stat_clr  input  1  synchronous clear of stall_cycles.
REQ-015 flush_ID  output  1  flush IF_ID.
REQ-016 flush_EX  output  1  insert bubble into ID_EX.
REQ-017 stall_PC_ID  output  1  hold PC and IF_ID.
REQ-018 pending  output  NREG  per-register "result outstanding" vector.
REQ-019 stall_cycles  output  SCW  saturating count of data-hazard stall cycles.

Function
REQ-020 Each register r != 0 shall own a countdown cnt[r] of LW bits; pending[r] = (cnt[r] != 0); pending[0] and cnt[0] shall be constant 0.
REQ-021 raw = (rs_read & pending[id_rs]) | (rt_read & pending[id_rt]), evaluated combinationally from current cnt.
REQ-022 waw = issue_wen & (issue_dst != 0) & pending[issue_dst] & (issue_lat < cnt[issue_dst]).
REQ-023 dhaz = issue_valid & (raw | waw).
REQ-024 When change_flow=1: flush_ID=1, flush_EX=1, stall_PC_ID=0, regardless of dhaz.
REQ-025 When change_flow=0: flush_ID=0, flush_EX=dhaz, stall_PC_ID=dhaz.
REQ-026 Issue commit = issue_valid & ~change_flow & ~dhaz.
REQ-027 Each cycle, every cnt[r] != 0 shall decrement by 1 and saturate at 0.
REQ-028 On issue commit with issue_wen=1, issue_dst != 0 and issue_lat != 0, cnt[issue_dst] shall load issue_lat instead of decrementing.
REQ-029 Issue commit with issue_lat=0, issue_wen=0 or issue_dst=0 shall leave the scoreboard unchanged except for decrements.
REQ-030 change_flow shall not modify cnt; older in-flight writes remain tracked.
REQ-031 stall_cycles shall increment by 1 on each cycle with dhaz & ~change_flow, saturate at 2**SCW-1, and clear to 0 on stat_clr; stat_clr has priority over increment.
REQ-032 Outputs flush_ID, flush_EX and stall_PC_ID shall be combinational, zero-latency; pending shall reflect registered state.

Reset
REQ-033 rst shall asynchronously force all cnt to 0 and stall_cycles to 0; pending=0 immediately.
REQ-034 During rst, outputs shall follow REQ-024/025 with an empty scoreboard: no data stall, flush_ID and flush_EX equal change_flow.
REQ-035 Reset asserted mid-operation shall discard all outstanding entries; no commit shall occur while rst=1.

Structure
REQ-036 NREG, LW and SCW defaults and the zero-register index shall live in package hazard_pkg.
REQ-037 The per-register countdown (load, decrement, saturate, pending flag) shall be sub-module hazard_sb_entry, instantiated NREG-1 times via generate.

Verification
REQ-038 Load-use: commit dst=5, lat=2; next cycle rs=5, rs_read=1 -> stall_PC_ID=flush_EX=1 for 2 cycles, then 0; stall_cycles=2.
REQ-039 Zero register: commit dst=0, lat=3; then rs=0 read -> no stall, pending=0.
REQ-040 WAW: dst=7 committed lat=5; next cycle (cnt=4) issue dst=7 lat=1 -> stall until cnt[7]<=1, then commit loads cnt[7]=1.
REQ-041 Flow change during stall: cnt[3]=2, rs=3 read, change_flow=1 -> flush_ID=flush_EX=1, stall_PC_ID=0, stall_cycles unchanged, cnt[3] decrements to 1.
REQ-042 Reset mid-flight: cnt[9]=4, assert rst between edges -> pending=0 immediately; after release rs=9 read -> no stall.
REQ-043 Counter saturation with SCW=2: 5 consecutive stall cycles -> stall_cycles=3; stat_clr with a stall in the same cycle -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared defaults and helpers for the register hazard scoreboard.
//   NREG_DEF  - number of architectural registers
//   LW_DEF    - width of a per-register latency countdown
//   SCW_DEF   - width of the data-hazard stall statistics counter
//   ZERO_REG  - index of the hardwired-zero register
//   flow_ctl  - maps (change_flow, data hazard) onto the pipeline controls
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int NREG_DEF = 32;
  localparam int LW_DEF   = 3;
  localparam int SCW_DEF  = 16;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic flush_id;
    logic flush_ex;
    logic stall_pc_id;
  } flow_ctl_t;

  // A resolved jump/mispredict squashes both IF_ID and ID_EX, so a data stall
  // in the same cycle is irrelevant: the stalled instruction is discarded.
  function automatic flow_ctl_t flow_ctl(input logic change_flow, input logic dhaz);
    flow_ctl_t c;
    c.flush_id    = change_flow;
    c.flush_ex    = change_flow | dhaz;
    c.stall_pc_id = ~change_flow & dhaz;
    return c;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// ID-stage <-> scoreboard signal bundle.
//   master : ID stage (drives source/issue info, receives flush/stall)
//   slave  : scoreboard (receives source/issue info, drives flush/stall)
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int RW = 5,
  parameter int LW = 3
) ();

  logic          change_flow;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          rs_read;
  logic          rt_read;
  logic          issue_valid;
  logic          issue_wen;
  logic [RW-1:0] issue_dst;
  logic [LW-1:0] issue_lat;
  logic          flush_ID;
  logic          flush_EX;
  logic          stall_PC_ID;

  modport master (
    output change_flow, id_rs, id_rt, rs_read, rt_read,
           issue_valid, issue_wen, issue_dst, issue_lat,
    input  flush_ID, flush_EX, stall_PC_ID
  );

  modport slave (
    input  change_flow, id_rs, id_rt, rs_read, rt_read,
           issue_valid, issue_wen, issue_dst, issue_lat,
    output flush_ID, flush_EX, stall_PC_ID
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// -----------------------------------------------------------------------------
// hazard_sb_entry
// One register's result-outstanding countdown.
//   clk, rst  - clock, asynchronous active-high reset
//   load      - committed write to this register with non-zero latency
//   load_val  - latency to load
//   cnt       - current countdown (0 = result readable)
//   pending   - cnt != 0
// -----------------------------------------------------------------------------
module hazard_sb_entry #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] load_val,
  output logic [LW-1:0] cnt,
  output logic          pending
);

  // NOTE: every scoreboard entry is reset, unlike a data RAM: a stale count
  // after reset would stall the pipeline on a write that no longer exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignment for all flop updates, so every entry
      // samples the same pre-edge values regardless of evaluation order.
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign pending = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks outstanding register writes and raises RAW/WAW data-hazard stalls;
// merges them with jump/mispredict flushes.
//   clk, rst      - clock, asynchronous active-high reset
//   sb (slave)    - ID-stage sources, issue info, flush/stall outputs
//   stat_clr      - synchronous clear of stall_cycles
//   pending       - per-register result-outstanding flags (registered)
//   stall_cycles  - saturating count of data-hazard stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int RW   = $clog2(NREG),
  parameter int LW   = LW_DEF,
  parameter int SCW  = SCW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  sb,
  input  logic                stat_clr,
  output logic [NREG-1:0]     pending,
  output logic [SCW-1:0]      stall_cycles
);

  logic [LW-1:0] cnt [NREG];
  logic          raw;
  logic          waw;
  logic          dhaz;
  logic          commit;
  flow_ctl_t     ctl;

  assign cnt[ZERO_REG]     = '0;
  assign pending[ZERO_REG] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    hazard_sb_entry #(.LW(LW)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (commit && sb.issue_wen && (sb.issue_dst == RW'(r)) &&
                 (sb.issue_lat != '0)),
      .load_val (sb.issue_lat),
      .cnt      (cnt[r]),
      .pending  (pending[r])
    );
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable
    // unassigned, which would otherwise infer a latch.
    raw  = 1'b0;
    waw  = 1'b0;
    raw  = (sb.rs_read & pending[sb.id_rs]) | (sb.rt_read & pending[sb.id_rt]);
    // A later write may only issue if it cannot complete before the older
    // one; otherwise the older write would land last and clobber it.
    waw  = sb.issue_wen && (sb.issue_dst != RW'(ZERO_REG)) &&
           pending[sb.issue_dst] && (sb.issue_lat < cnt[sb.issue_dst]);
    dhaz = sb.issue_valid & (raw | waw);
  end

  // Reset holds every entry at zero, so no commit can take effect during rst.
  assign commit = sb.issue_valid & ~sb.change_flow & ~dhaz;

  assign ctl            = flow_ctl(sb.change_flow, dhaz);
  assign sb.flush_ID    = ctl.flush_id;
  assign sb.flush_EX    = ctl.flush_ex;
  assign sb.stall_PC_ID = ctl.stall_pc_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stat_clr) begin
      stall_cycles <= '0;
    end else if (dhaz && !sb.change_flow && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed vectors push their hand-derived expected outputs into a queue; a
// monitor on the falling edge pops and compares. A second instance with a
// 2-bit stall counter shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  typedef struct {
    string       name;
    logic        fid;
    logic        fex;
    logic        stl;
    logic [31:0] pend;
    logic [15:0] sc;
    logic [1:0]  sc2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_clr;
  logic [31:0] pending;
  logic [15:0] stall_cycles;
  logic [31:0] pending2;
  logic [1:0]  stall_cycles2;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  hazard_scoreboard_if #(.RW(5), .LW(3)) sb  ();
  hazard_scoreboard_if #(.RW(5), .LW(3)) sb2 ();

  assign sb2.change_flow = sb.change_flow;
  assign sb2.id_rs       = sb.id_rs;
  assign sb2.id_rt       = sb.id_rt;
  assign sb2.rs_read     = sb.rs_read;
  assign sb2.rt_read     = sb.rt_read;
  assign sb2.issue_valid = sb.issue_valid;
  assign sb2.issue_wen   = sb.issue_wen;
  assign sb2.issue_dst   = sb.issue_dst;
  assign sb2.issue_lat   = sb.issue_lat;

  hazard_scoreboard u_dut (
    .clk          (clk),
    .rst          (rst),
    .sb           (sb),
    .stat_clr     (stat_clr),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  hazard_scoreboard #(.SCW(2)) u_dut_sat (
    .clk          (clk),
    .rst          (rst),
    .sb           (sb2),
    .stat_clr     (stat_clr),
    .pending      (pending2),
    .stall_cycles (stall_cycles2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, after inputs change at posedge+1.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".flush_ID"},     64'(sb.flush_ID),      64'(e.fid));
      check({e.name, ".flush_EX"},     64'(sb.flush_EX),      64'(e.fex));
      check({e.name, ".stall_PC_ID"},  64'(sb.stall_PC_ID),   64'(e.stl));
      check({e.name, ".pending"},      64'(pending),          64'(e.pend));
      check({e.name, ".stall_cycles"}, 64'(stall_cycles),     64'(e.sc));
      check({e.name, ".sat_cycles"},   64'(stall_cycles2),    64'(e.sc2));
    end
  end

  task automatic drive(input logic v, input logic w, input logic [4:0] dst,
                       input logic [2:0] lat, input logic [4:0] rs, input logic rsr,
                       input logic [4:0] rt, input logic rtr, input logic cf,
                       input logic clr);
    sb.issue_valid = v;
    sb.issue_wen   = w;
    sb.issue_dst   = dst;
    sb.issue_lat   = lat;
    sb.id_rs       = rs;
    sb.rs_read     = rsr;
    sb.id_rt       = rt;
    sb.rt_read     = rtr;
    sb.change_flow = cf;
    stat_clr       = clr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Queue the expectation for the current cycle, then move to the next one.
  task automatic expect_v(input string name, input logic fid, input logic fex,
                          input logic stl, input logic [31:0] pend,
                          input logic [15:0] sc, input logic [1:0] sc2);
    exp_t e;
    e.name = name; e.fid = fid; e.fex = fex; e.stl = stl;
    e.pend = pend; e.sc = sc; e.sc2 = sc2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Reset: empty scoreboard, flushes follow change_flow, no commit.
    expect_v("rst_idle", 0, 0, 0, 32'h0, 0, 0);
    drive(1, 1, 5, 2, 5, 1, 0, 0, 1, 0);
    expect_v("rst_cf", 1, 1, 0, 32'h0, 0, 0);
    rst = 1'b0;
    idle();
    expect_v("rst_rel", 0, 0, 0, 32'h0, 0, 0);

    // Load-use: dst=5 lat=2 then read r5.
    drive(1, 1, 5, 2, 0, 0, 0, 0, 0, 0);
    expect_v("lu_commit", 0, 0, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    expect_v("lu_stall1", 0, 1, 1, 32'h20, 0, 0);
    expect_v("lu_stall2", 0, 1, 1, 32'h20, 1, 1);
    expect_v("lu_go",     0, 0, 0, 32'h0,  2, 2);

    // Zero register never becomes pending.
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    expect_v("z_commit", 0, 0, 0, 32'h0, 2, 2);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    expect_v("z_read", 0, 0, 0, 32'h0, 2, 2);

    // WAW: dst=7 lat=5, idle once (cnt=4), then dst=7 lat=1 stalls to cnt=1.
    drive(1, 1, 7, 5, 0, 0, 0, 0, 0, 0);
    expect_v("waw_commit", 0, 0, 0, 32'h0, 2, 2);
    idle();
    expect_v("waw_wait", 0, 0, 0, 32'h80, 2, 2);
    drive(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    expect_v("waw_s4", 0, 1, 1, 32'h80, 2, 2);
    expect_v("waw_s3", 0, 1, 1, 32'h80, 3, 3);
    expect_v("waw_s2", 0, 1, 1, 32'h80, 4, 3);
    expect_v("waw_go", 0, 0, 0, 32'h80, 5, 3);
    // Pending source but no valid instruction: no stall.
    drive(0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    expect_v("waw_load", 0, 0, 0, 32'h80, 5, 3);
    idle();
    expect_v("waw_done", 0, 0, 0, 32'h0, 5, 3);

    // Flow change during a RAW stall: flush wins, no commit, no stat count.
    drive(1, 1, 3, 2, 0, 0, 0, 0, 0, 0);
    expect_v("cf_commit", 0, 0, 0, 32'h0, 5, 3);
    drive(1, 1, 4, 3, 3, 1, 0, 0, 1, 0);
    expect_v("cf_flush", 1, 1, 0, 32'h8, 5, 3);
    idle();
    expect_v("cf_after", 0, 0, 0, 32'h8, 5, 3);
    expect_v("cf_done",  0, 0, 0, 32'h0, 5, 3);

    // Reset mid-flight drops r9's outstanding write.
    drive(1, 1, 9, 4, 0, 0, 0, 0, 0, 0);
    expect_v("rm_commit", 0, 0, 0, 32'h0, 5, 3);
    idle();
    expect_v("rm_pend", 0, 0, 0, 32'h200, 5, 3);
    rst = 1'b1;
    drive(1, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    expect_v("rm_rst", 0, 0, 0, 32'h0, 0, 0);
    rst = 1'b0;
    expect_v("rm_rel", 0, 0, 0, 32'h0, 0, 0);

    // Saturation: 5 stalls on r6 (via rs then rt), then stat_clr during a stall.
    drive(1, 1, 6, 7, 0, 0, 0, 0, 0, 0);
    expect_v("sat_commit", 0, 0, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    expect_v("sat1", 0, 1, 1, 32'h40, 0, 0);
    expect_v("sat2", 0, 1, 1, 32'h40, 1, 1);
    expect_v("sat3", 0, 1, 1, 32'h40, 2, 2);
    drive(1, 0, 0, 0, 6, 0, 6, 1, 0, 0);
    expect_v("sat4", 0, 1, 1, 32'h40, 3, 3);
    expect_v("sat5", 0, 1, 1, 32'h40, 4, 3);
    drive(1, 0, 0, 0, 6, 0, 6, 1, 0, 1);
    expect_v("sat_clr", 0, 1, 1, 32'h40, 5, 3);
    drive(1, 0, 0, 0, 6, 0, 6, 0, 0, 0);
    expect_v("sat_after", 0, 0, 0, 32'h40, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
